// File: rtl/core_mem_pkg.sv
// Shared encodings for the core_mem stage: FSM states, opcodes, func3 widths and
// exception causes, plus the access-legality check used at accept time.
package core_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_WAIT_R = 2'b10
  } mem_state_e;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_LOAD_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_STORE_MIS = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b11;

  // Illegal width takes priority over misalignment.
  function automatic logic [1:0] access_fault(input logic       is_store,
                                              input logic [2:0] func3,
                                              input logic [1:0] off);
    logic       illegal;
    logic       misaligned;
    logic [1:0] cause;
    if (is_store) illegal = func3[2] | (func3[1:0] == 2'b11);
    else          illegal = (func3[1:0] == 2'b11) | (func3 == 3'b110);
    misaligned = ((func3[1:0] == 2'b01) && off[0]) ||
                 ((func3[1:0] == 2'b10) && (off != 2'b00));
    cause = CAUSE_NONE;
    if (illegal)         cause = CAUSE_ILLEGAL;
    else if (misaligned) cause = is_store ? CAUSE_STORE_MIS : CAUSE_LOAD_MIS;
    return cause;
  endfunction

endpackage

// File: rtl/core_mem_align.sv
// Byte-lane helper: store byte enables / lane-replicated write data, and load
// lane extraction with sign or zero extension.
module core_mem_align (
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] lane;
  logic        sext;

  always_comb begin
    lane        = rdata_i >> {off_i, 3'b000};
    sext        = ~func3_i[2];
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = lane;
    case (func3_i[1:0])
      2'b00: begin
        be_o        = 4'b0001 << off_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{sext & lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        be_o        = 4'b0011 << off_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = {{16{sext & lane[15]}}, lane[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_mem.sv
// Memory-access stage: ALU results pass through one register; loads and stores
// run a req/gnt/rvalid bus transaction; bad accesses raise an exception pulse.
module core_mem
  import core_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_in,
  output logic        ex_ready_out,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  func3_in,
  input  logic        reg_we_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] reg_write_data_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] store_data_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_gnt_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in,
  output logic        reg_we_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] reg_write_data_out,
  output logic        exc_valid_out,
  output logic [1:0]  exc_cause_out,
  output logic [31:0] exc_addr_out
);

  mem_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        rwe_q, rwe_d;
  logic [4:0]  raddr_q, raddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exc_q, exc_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] eaddr_q, eaddr_d;

  logic        is_store, is_mem;
  logic [1:0]  fault;
  logic [2:0]  al_func3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  // In IDLE the helper sees the incoming access; afterwards the latched one.
  assign al_func3 = (state_q == ST_IDLE) ? func3_in : func3_q;
  assign al_off   = (state_q == ST_IDLE) ? mem_addr_in[1:0] : off_q;

  core_mem_align u_align (
    .func3_i      (al_func3),
    .off_i        (al_off),
    .store_data_i (store_data_in),
    .rdata_i      (mem_rdata_in),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  assign is_store = (opcode_in == INST_TYPE_S);
  assign is_mem   = is_store || (opcode_in == INST_TYPE_L);
  assign fault    = access_fault(is_store, func3_in, mem_addr_in[1:0]);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    func3_d = func3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    rwe_d   = 1'b0;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    exc_d   = 1'b0;
    cause_d = cause_q;
    eaddr_d = eaddr_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid_in && !is_mem) begin
          rwe_d   = reg_we_in && (reg_write_addr_in != 5'd0);
          raddr_d = reg_write_addr_in;
          rdata_d = reg_write_data_in;
        end else if (ex_valid_in && (fault != CAUSE_NONE)) begin
          exc_d   = 1'b1;
          cause_d = fault;
          eaddr_d = mem_addr_in;
        end else if (ex_valid_in) begin
          state_d = ST_REQ;
          we_d    = is_store;
          addr_d  = {mem_addr_in[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = is_store ? al_wdata : 32'h0;
          func3_d = func3_in;
          off_d   = mem_addr_in[1:0];
          rd_d    = reg_write_addr_in;
        end
      end
      ST_REQ: begin
        if (mem_gnt_in) state_d = we_q ? ST_IDLE : ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (mem_rvalid_in) begin
          rwe_d   = (rd_q != 5'd0);
          raddr_d = rd_q;
          rdata_d = al_load;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      func3_q <= 3'h0;
      off_q   <= 2'h0;
      rd_q    <= 5'h0;
      rwe_q   <= 1'b0;
      raddr_q <= 5'h0;
      rdata_q <= 32'h0;
      exc_q   <= 1'b0;
      cause_q <= 2'h0;
      eaddr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      rwe_q   <= rwe_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign ex_ready_out       = (state_q == ST_IDLE);
  assign mem_req_out        = (state_q == ST_REQ);
  assign mem_we_out         = we_q;
  assign mem_addr_out       = addr_q;
  assign mem_be_out         = be_q;
  assign mem_wdata_out      = wdata_q;
  assign reg_we_out         = rwe_q;
  assign reg_write_addr_out = raddr_q;
  assign reg_write_data_out = rdata_q;
  assign exc_valid_out      = exc_q;
  assign exc_cause_out      = cause_q;
  assign exc_addr_out       = eaddr_q;

endmodule

// File: doc/core_mem.md
# core_mem

Memory-access stage of the xRV32I core, directly downstream of `core_ex`. It accepts one EX result per handshake. ALU results pass through to the register write port after one registered cycle. Loads and stores run a req/gnt/rvalid data-bus transaction with byte-lane alignment and sign/zero extension. Misaligned or illegal-width accesses raise a one-cycle exception pulse instead of touching the bus.

## Interface
- No parameters; address and data buses fixed at 32 bits.
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ex_valid_in`  in  1  EX result valid this cycle
- `ex_ready_out`  out  1  stage can accept (1 only in IDLE)
- `opcode_in`  in  7  instruction opcode
- `func3_in`  in  3  access width/sign
- `reg_we_in`  in  1  EX write-enable
- `reg_write_addr_in`  in  5  rd
- `reg_write_data_in`  in  32  ALU result from `core_ex`
- `mem_addr_in`  in  32  effective address rs1+imm
- `store_data_in`  in  32  rs2 value
- `mem_req_out`  out  1  bus request
- `mem_we_out`  out  1  1 = store
- `mem_addr_out`  out  32  word-aligned address, bits [1:0] = 0
- `mem_be_out`  out  4  byte enables
- `mem_wdata_out`  out  32  lane-replicated store data
- `mem_gnt_in`  in  1  request accepted
- `mem_rvalid_in`  in  1  load data valid
- `mem_rdata_in`  in  32  load data word
- `reg_we_out`  out  1  register write strobe
- `reg_write_addr_out`  out  5  rd
- `reg_write_data_out`  out  32  write data
- `exc_valid_out`  out  1  exception pulse
- `exc_cause_out`  out  2  01 misaligned load, 10 misaligned store, 11 illegal width
- `exc_addr_out`  out  32  faulting `mem_addr_in`

## Operation
- FSM states: IDLE, REQ, WAIT_R. Reset enters IDLE. `ex_ready_out` is a decode of the state register only; no combinational path from inputs.
- IDLE with `ex_valid_in`:
  - Non-memory opcode: register `reg_we_in`, `reg_write_addr_in`, `reg_write_data_in` to the outputs. Stay in IDLE.
  - LOAD (0000011): func3 011, 110, 111 -> cause 11. LH/LHU with addr[0]=1 -> cause 01. LW with addr[1:0]≠0 -> cause 01.
  - STORE (0100011): func3 > 010 -> cause 11. Misalignment as for loads -> cause 10.
  - Any exception: pulse `exc_valid_out` for one cycle, no bus request, no register write, stay in IDLE.
  - Otherwise latch all fields and go to REQ.
- REQ: `mem_req_out`=1. Address, we, be and wdata are held stable until `mem_gnt_in`. On grant, a store goes to IDLE (store completes at grant) and a load goes to WAIT_R. `mem_rvalid_in` in REQ is ignored.
- WAIT_R: on `mem_rvalid_in`, select the lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Register the result with `reg_we_out`=1 for one cycle (0 if rd=0), then go to IDLE.
- Byte enables: SB/LB = 0001<<addr[1:0]; SH/LH = 0011<<addr[1:0]; W = 1111.
- Store data: SB = {4{rs2[7:0]}}, SH = {2{rs2[15:0]}}, SW = rs2.
- Every write to x0 is suppressed, both ALU and load writes.
- `mem_rvalid_in` in IDLE is ignored.

## Timing
- Reset values: all outputs 0 except `ex_ready_out`=1.
- Reset asserted mid-transaction drops `mem_req_out` immediately and abandons the access. Any later rvalid is ignored.
- ALU pass-through latency: 1 cycle (accept at edge E0, outputs valid after E0).
- Load with zero-wait memory:
  - Accepted at E0, `mem_req_out` high during E0–E1.
  - gnt sampled at E1.
  - rvalid sampled at E2; write data valid after E2, which is 3 cycles.
- Store: accepted at E0, gnt at E1, `ex_ready_out` back to 1 after E1.
- Each wait-cycle on gnt or rvalid adds exactly 1 cycle.
- `exc_valid_out` and `reg_we_out` are single-cycle pulses, registered.

## Structure
- Add to `defines.v`: `INST_TYPE_L`, `INST_TYPE_S`; func3 codes LB/LH/LW/LBU/LHU/SB/SH/SW; MEM state encodings; exception cause codes.
- Sub-module `core_mem_align`: combinational byte-enable and store-data generation plus load lane extraction and extension. It is shared by both paths and unit-testable.

## Test plan
- ALU pass-through: `reg_write_data_in`=0x12345678, rd=5 -> next cycle `reg_we_out`=1, addr 5, data 0x12345678. Repeat with rd=0 -> `reg_we_out`=0.
- LB at addr 0x1003, rdata 0x80FF_FF_FF -> `mem_addr_out`=0x1000, be=1000, write 0xFFFFFF80. LBU same -> 0x00000080.
- SH at 0x2002 with rs2=0xAAAA1234 -> be=1100, wdata=0x12341234, we=1. Hold gnt low 3 cycles -> outputs stable, `ex_ready_out`=0 until grant.
- LW at 0x3001 -> `exc_valid_out` pulse, cause 01, `exc_addr_out`=0x3001, no `mem_req_out`. SW at 0x3002 -> cause 10. Load func3=011 -> cause 11.
- LHU at 0x4002, gnt immediate, rvalid after 2 wait cycles, rdata 0xBEEF0000 -> data 0x0000BEEF, total latency 5 cycles.
- Reset pulsed while in WAIT_R -> `mem_req_out`=0 and `ex_ready_out`=1 at once. A subsequent rvalid produces no register write.
